// File: rtl/pipe_issue_scheduler.sv
// pipe_issue_scheduler
// Issue/interlock controller that sits between IF/ID and ID/EX of the
// 5-stage pipe_MIPS32 datapath. It does three things:
//   - tracks in-flight register writes in a small shift-register scoreboard
//     and stalls any instruction that reads one of them;
//   - squashes the ID instruction when a branch resolves taken in EX;
//   - handles HLT by stopping issue, draining the pipeline, and then
//     asserting halted.
// The control outputs are combinational and respond in the same cycle.
// While rst_n is low they follow the RUN rules against an empty scoreboard.

module pipe_issue_scheduler #(
    parameter int HAZ_DEPTH = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [4:0]       id_dest,
    input  logic             id_wr_en,
    input  logic             id_halt,
    input  logic             ex_taken,
    output logic             issue,
    output logic             stall_if,
    output logic             bubble,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    state_t               cur_state;
    logic [2:0]           drain_cnt;
    logic [2:0]           drain_nxt;
    logic [HAZ_DEPTH-1:0] sb_v;
    logic [4:0]           sb_dest [HAZ_DEPTH];
    logic [HAZ_DEPTH-1:0] live_v;
    logic                 rs_hit;
    logic                 rt_hit;
    logic                 hazard;
    logic                 stall_inc;
    logic                 sb_load;

    // While reset is asserted, the outputs behave as if we were in RUN with
    // an empty scoreboard. Any stall or drain in progress is abandoned at once.
    assign cur_state = rst_n ? state : RUN;
    assign live_v    = rst_n ? sb_v : '0;

    // Compare both sources against every valid in-flight destination.
    // The check uses the scoreboard as it is now, before this cycle's shift.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (live_v[i] && (sb_dest[i] == id_rs)) rs_hit = 1'b1;
            if (live_v[i] && (sb_dest[i] == id_rt)) rt_hit = 1'b1;
        end
        hazard = id_valid &
                 ((id_rs_used & (id_rs != 5'd0) & rs_hit) |
                  (id_rt_used & (id_rt != 5'd0) & rt_hit));
    end

    // Next-state and control outputs. In RUN, a taken branch has priority
    // over a hazard, and a hazard has priority over normal issue.
    always_comb begin
        state_nxt = cur_state;
        drain_nxt = drain_cnt;
        issue     = 1'b0;
        stall_if  = 1'b0;
        bubble    = 1'b0;
        flush     = 1'b0;
        halted    = 1'b0;
        stall_inc = 1'b0;
        case (cur_state)
            RUN: begin
                if (ex_taken) begin
                    flush  = rst_n;
                    bubble = 1'b1;
                end else if (hazard) begin
                    stall_if  = 1'b1;
                    bubble    = 1'b1;
                    stall_inc = 1'b1;
                end else if (id_valid) begin
                    issue = 1'b1;
                    if (id_halt) begin
                        state_nxt = DRAIN;
                        drain_nxt = 3'(HAZ_DEPTH);
                    end
                end else begin
                    bubble = 1'b1;
                end
            end
            DRAIN: begin
                stall_if  = 1'b1;
                bubble    = 1'b1;
                drain_nxt = drain_cnt - 3'd1;
                if (drain_cnt == 3'd1) state_nxt = HALT;
            end
            HALT: begin
                halted   = 1'b1;
                stall_if = 1'b1;
                bubble   = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // A scoreboard entry is created only for an issued instruction that
    // writes a real register. R0 is never tracked.
    assign sb_load = issue & id_wr_en & (id_dest != 5'd0);

    // State register, drain counter, stall counter and scoreboard shift.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 3'd0;
            stall_cnt <= '0;
            sb_v      <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) sb_dest[i] <= 5'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                sb_v[i]    <= sb_v[i-1];
                sb_dest[i] <= sb_dest[i-1];
            end
            sb_v[0]    <= sb_load;
            sb_dest[0] <= sb_load ? id_dest : 5'd0;
        end
    end

endmodule

// File: tb/tb_pipe_issue_scheduler.sv
// tb_pipe_issue_scheduler
// A directed bench for pipe_issue_scheduler with the default parameters
// (HAZ_DEPTH=3, CNT_W=16). Inputs change 1 ns after the rising edge. The
// combinational controls are compared mid-cycle, and stall_cnt is compared
// just after the edge.
// The control vector is ordered {issue, stall_if, bubble, flush, halted}.

module tb_pipe_issue_scheduler;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [4:0]  id_dest;
    logic        id_wr_en;
    logic        id_halt;
    logic        ex_taken;
    logic        issue;
    logic        stall_if;
    logic        bubble;
    logic        flush;
    logic        halted;
    logic [15:0] stall_cnt;

    int passCount = 0;
    int totalCount = 0;

    localparam logic [4:0] IDLE = 5'b00100;
    localparam logic [4:0] ISS  = 5'b10000;
    localparam logic [4:0] STL  = 5'b01100;
    localparam logic [4:0] FLU  = 5'b00110;
    localparam logic [4:0] HLTD = 5'b01101;

    pipe_issue_scheduler #(.HAZ_DEPTH(3), .CNT_W(16)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used),
        .id_dest   (id_dest),
        .id_wr_en  (id_wr_en),
        .id_halt   (id_halt),
        .ex_taken  (ex_taken),
        .issue     (issue),
        .stall_if  (stall_if),
        .bubble    (bubble),
        .flush     (flush),
        .halted    (halted),
        .stall_cnt (stall_cnt)
    );

    // Free-running 10 ns clock.
    always #5 clk1 = ~clk1;

    // Drive one cycle's worth of ID-stage inputs.
    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic rsu,
                                 input logic [4:0] rt, input logic rtu,
                                 input logic [4:0] dest, input logic wr,
                                 input logic hlt, input logic taken);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_dest    = dest;
        id_wr_en   = wr;
        id_halt    = hlt;
        ex_taken   = taken;
    endtask

    // Compare the control vector in mid-cycle.
    task automatic checkOutput(input string tag, input logic [4:0] expected);
        logic [4:0] observed;
        #4;
        observed = {issue, stall_if, bubble, flush, halted};
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed ctl=%b expected ctl=%b", tag, observed, expected);
    endtask

    // Compare the stall statistics counter.
    task automatic checkCount(input string tag, input logic [15:0] expected);
        totalCount++;
        assert (stall_cnt === expected) passCount++;
        else $error("FAIL %s: observed stall_cnt=%0d expected stall_cnt=%0d", tag, stall_cnt, expected);
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput(tag, IDLE);
        tick();
    endtask

    // The directed sequence. Comments give the scoreboard contents
    // (entry0, entry1, entry2) that the hand-computed expectations rely on.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        // Reset cycle with ex_taken high: flush must stay low.
        checkOutput("reset_taken", IDLE);
        tick();
        rst_n = 1'b1;
        checkCount("reset_cnt", 16'd0);
        idleCycle("post_reset_idle");

        // Back-to-back: ADDI R1 then ADD R4,R1,R2 stalls exactly 3 cycles.
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b_prod", ISS);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
            checkOutput("b2b_stall", STL);
            tick();
        end
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b_issue", ISS);
        tick();
        checkCount("b2b_cnt", 16'd3);
        for (int i = 0; i < 3; i++) idleCycle("idle_drain_r4");

        // Independent stream: ADDI R1, R2, R3 issue on consecutive cycles.
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'(i), 1'b1, 1'b0, 1'b0);
            checkOutput("indep_issue", ISS);
            tick();
        end
        checkCount("indep_cnt", 16'd3);

        // R0 as destination, then a reader of R0: neither stalls.
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("r0_dest", ISS);
        tick();
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("r0_read", ISS);
        tick();

        // Producer R6. An unused rs=R6 must not stall. The rt=R6 reader
        // stalls while R6 sits in entry1 and entry2.
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        checkOutput("prod_r6", ISS);
        tick();
        applyStimulus(1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("unused_src", ISS);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
            checkOutput("rt_stall", STL);
            tick();
        end
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("rt_issue", ISS);
        tick();
        checkCount("rt_cnt", 16'd5);

        // Taken branch while the ID instruction depends on pending R5.
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        checkOutput("prod_r5", ISS);
        tick();
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
        checkOutput("taken_haz", FLU);
        tick();
        checkCount("taken_cnt", 16'd5);
        for (int i = 0; i < 3; i++) idleCycle("idle_drain_r5");

        // HLT issued at t. DRAIN runs t+1..t+3, HALT from t+4, and nothing
        // issues afterwards. ex_taken is ignored in DRAIN and HALT.
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("prod_r7", ISS);
        tick();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("hlt_issue", ISS);
        tick();
        applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
        checkOutput("drain_taken", STL);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
            checkOutput("drain", STL);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'(i));
            checkOutput("halted", HLTD);
            tick();
        end

        // Reset out of HALT.
        rst_n = 1'b0;
        idleCycle("rst_halt");
        rst_n = 1'b1;
        checkCount("rst_cnt", 16'd0);

        // Reset mid-drain while R7 is still tracked. Afterwards, a reader of
        // R7 must issue at once.
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        checkOutput("prod_r7b", ISS);
        tick();
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("hlt_issue_b", ISS);
        tick();
        rst_n = 1'b0;
        idleCycle("rst_drain");
        rst_n = 1'b1;
        applyStimulus(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_r7", ISS);
        tick();
        applyStimulus(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("post_rst_r8", STL);
        tick();
        checkCount("post_rst_cnt", 16'd1);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
